// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: owns the fetch PC, drives a 1-cycle-latency imem, buffers words in a prefetch queue.
// Optional macro FETCH_PERF_CNT_EN builds the saturating perf_fetched / perf_stall counters.
module fetch_queue_unit #(
   parameter int unsigned DEPTH     = 4,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_addr,
   output logic        imem_req,
   input  logic [31:0] imem_rdata,
   input  logic        imem_rvalid,
   output logic [31:0] instr_out,
   output logic [31:0] pc_plus4_out,
   output logic        out_valid,
   input  logic        out_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        halted,
   output logic [15:0] perf_fetched,
   output logic [15:0] perf_stall
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   localparam logic [1:0] ST_RUN  = 2'd0;
   localparam logic [1:0] ST_FULL = 2'd1;
   localparam logic [1:0] ST_HALT = 2'd2;

   logic [31:0]   r_fetch_pc;
   logic [31:0]   r_req_addr;
   logic [31:0]   r_instr_mem [DEPTH];
   logic [31:0]   r_pc4_mem   [DEPTH];
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;
   logic          r_in_flight;
   logic          r_discard;
   logic [1:0]    r_state;
   logic [31:0]   r_last_instr;
   logic [31:0]   r_last_pc4;

   logic          w_out_valid;
   logic          w_push;
   logic          w_pop;
   logic          w_halt_in;
   logic          w_issue;
   logic [CW-1:0] w_count_next;

   assign w_out_valid  = (r_count != '0);
   assign w_push       = imem_rvalid && !r_discard && !redirect && !reset;
   assign w_pop        = w_out_valid && out_ready && !redirect && !reset;
   assign w_halt_in    = w_push && (imem_rdata == HALT_WORD);
   assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

   // A HALT word arriving this cycle already blocks the next request, so nothing is fetched past it.
   assign w_issue = !reset && !redirect && (r_state != ST_HALT) && !w_halt_in
                    && ((r_count + CW'(r_in_flight)) < CW'(DEPTH));

   assign imem_addr    = r_fetch_pc;
   assign imem_req     = w_issue;
   assign out_valid    = w_out_valid;
   assign instr_out    = w_out_valid ? r_instr_mem[r_rd_ptr] : r_last_instr;
   assign pc_plus4_out = w_out_valid ? r_pc4_mem[r_rd_ptr]   : r_last_pc4;
   assign halted       = (r_state == ST_HALT);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_fetch_pc  <= RESET_PC;
         r_req_addr  <= RESET_PC;
         r_rd_ptr    <= '0;
         r_wr_ptr    <= '0;
         r_count     <= '0;
         r_in_flight <= 1'b0;
         r_discard   <= 1'b1;
         r_state     <= ST_RUN;
      end else if (redirect) begin
         r_fetch_pc  <= redirect_pc;
         r_rd_ptr    <= '0;
         r_wr_ptr    <= '0;
         r_count     <= '0;
         r_in_flight <= 1'b0;
         r_discard   <= 1'b1;
         r_state     <= ST_RUN;
      end else begin
         r_discard   <= 1'b0;
         r_in_flight <= w_issue;
         if (w_issue) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
            r_req_addr <= r_fetch_pc;
         end
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= w_count_next;
         if (r_state == ST_HALT || w_halt_in)
            r_state <= ST_HALT;
         else if ((w_count_next + CW'(w_issue)) == CW'(DEPTH))
            r_state <= ST_FULL;
         else
            r_state <= ST_RUN;
      end
   end

   // NOTE: queue storage has no reset; out_valid gates every read, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_instr_mem[r_wr_ptr] <= imem_rdata;
         r_pc4_mem[r_wr_ptr]   <= r_req_addr + 32'd4;
      end
   end

   // Remember the last presented head so the outputs hold steady while the queue is empty.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_last_instr <= '0;
         r_last_pc4   <= '0;
      end else if (w_out_valid) begin
         r_last_instr <= r_instr_mem[r_rd_ptr];
         r_last_pc4   <= r_pc4_mem[r_rd_ptr];
      end
   end

   assert property (@(posedge clk) disable iff (reset)
      !(w_push && !w_pop && (r_count == CW'(DEPTH))))
      else $error("fetch_queue_unit: push into a full queue");

`ifdef FETCH_PERF_CNT_EN
   logic [15:0] r_perf_fetched;
   logic [15:0] r_perf_stall;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_perf_fetched <= '0;
         r_perf_stall   <= '0;
      end else begin
         if (w_push && r_perf_fetched != 16'hFFFF)
            r_perf_fetched <= r_perf_fetched + 16'd1;
         if (w_out_valid && !out_ready && r_perf_stall != 16'hFFFF)
            r_perf_stall <= r_perf_stall + 16'd1;
      end
   end

   assign perf_fetched = r_perf_fetched;
   assign perf_stall   = r_perf_stall;
`else
   assign perf_fetched = 16'd0;
   assign perf_stall   = 16'd0;
`endif

endmodule
